// File: rtl/uart_mailbox.sv
// uart_mailbox
//   Word-addressed mailbox with a streaming TX port. Software fills payload
//   words through the write port, then writes CTRL (index DEPTH-1) with a
//   length LEN in its low log2(DEPTH) bits. The block then streams payload
//   words 0..LEN-1 over a valid/ready port, pulses o_done once, clears CTRL
//   and returns to idle.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_write_en            write strobe (one word per cycle)
//   i_addres_write        write address; memory index = address - BASE
//   i_data                write data
//   i_addres_read         read address, used directly as the memory index
//   o_data                registered read data (1-cycle latency)
//   o_tx_valid/o_tx_data  TX word offered to the consumer
//   i_tx_ready            TX consumer ready
//   o_busy                stream in progress
//   o_done                one-cycle pulse at the end of a stream
//   o_err                 sticky write error (cleared only by reset)
module uart_mailbox #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int BASE   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_write_en,
  input  logic [31:0]       i_addres_write,
  input  logic [DATA_W-1:0] i_data,
  input  logic [31:0]       i_addres_read,
  output logic [DATA_W-1:0] o_data,
  output logic              o_tx_valid,
  output logic [DATA_W-1:0] o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [31:0] CTRL_IDX = 32'(DEPTH - 1);
  localparam logic [31:0] BASE_W   = 32'(BASE);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] ctrl;
  logic [AW-1:0]     cnt;
  logic [AW-1:0]     len;
  // The top entry shadows CTRL and is never written; keeping the array a
  // full power of two lets every AW-bit index address it directly.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write decode. The subtraction wraps, so addresses below BASE land far
  // above DEPTH and are rejected by the same unsigned range test.
  logic [31:0]   wr_idx;
  logic          wr_in_range;
  logic          wr_is_ctrl;
  logic          idle;
  logic          payload_we;
  logic          ctrl_we;
  logic          wr_err;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] new_len;
  logic [AW-1:0] cnt_next;

  assign wr_idx      = i_addres_write - BASE_W;
  assign wr_in_range = wr_idx < DEPTH_W;
  assign wr_is_ctrl  = wr_idx == CTRL_IDX;
  assign wr_addr     = wr_idx[AW-1:0];
  assign idle        = state == IDLE;
  assign payload_we  = i_write_en && wr_in_range && !wr_is_ctrl && idle;
  assign ctrl_we     = i_write_en && wr_is_ctrl && idle;
  // Out-of-range writes always flag; CTRL writes while busy are dropped
  // quietly, payload writes while busy are dropped and flagged.
  assign wr_err      = i_write_en && (!wr_in_range || (!idle && !wr_is_ctrl));
  // LEN is AW bits wide, so it can never exceed DEPTH-1: min(LEN, DEPTH-1)
  // is simply LEN and CNT cannot wrap.
  assign new_len     = i_data[AW-1:0];
  assign cnt_next    = cnt + 1'b1;

  // Read decode
  logic          rd_in_range;
  logic          rd_is_ctrl;
  logic [AW-1:0] rd_addr;

  assign rd_in_range = i_addres_read < DEPTH_W;
  assign rd_is_ctrl  = i_addres_read == CTRL_IDX;
  assign rd_addr     = i_addres_read[AW-1:0];

  // NOTE: payload memory has no reset so it can map onto a RAM; only the
  // control state below is cleared by i_rst.
  always_ff @(posedge i_clk) begin
    if (payload_we) begin
      mem[wr_addr] <= i_data;
    end
  end

  // NOTE: non-blocking assignments throughout, so every register (and the
  // read port) sees pre-edge values; a same-cycle read of a word being
  // written returns the old data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      ctrl       <= '0;
      o_data     <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      if (!rd_in_range) begin
        o_data <= '0;
      end else if (rd_is_ctrl) begin
        o_data <= ctrl;
      end else begin
        o_data <= mem[rd_addr];
      end

      if (wr_err) begin
        o_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (ctrl_we) begin
            ctrl <= i_data;
            if (new_len != '0) begin
              len    <= new_len;
              cnt    <= '0;
              o_busy <= 1'b1;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          o_tx_data  <= mem[cnt];
          o_tx_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (i_tx_ready) begin
            cnt        <= cnt_next;
            o_tx_valid <= 1'b0;
            if (cnt_next == len) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          ctrl   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
